// File: rtl/i2c_resp_pkg.sv
// Shared types and constants for the PCF8591-style I2C ADC responder.
package i2c_resp_pkg;

  // Protocol states of the target engine
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_A_ACK  = 3'd2,
    ST_WR     = 3'd3,
    ST_W_ACK  = 3'd4,
    ST_RD     = 3'd5,
    ST_R_ACK  = 3'd6,
    ST_IGNORE = 3'd7
  } state_t;

  // Bus address our master uses for the PCF8591
  localparam logic [6:0] DEFAULT_ADDR = 7'h49;

  // Control-byte field positions
  localparam int CH_LSB      = 0;
  localparam int AUTOINC_BIT = 2;
  localparam int AOUT_EN_BIT = 6;

endpackage

// File: rtl/i2c_line_filter.sv
// One bus line: 2-FF synchronizer, FILT_LEN-cycle glitch filter and
// rise/fall pulses on the filtered level. Lines idle high, so the
// filtered level resets to 1.
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [2:0] LAST_CNT = 3'(FILT_LEN - 1);

  logic [1:0] sync_r;
  logic       filt_r;
  logic [2:0] cnt_r;
  logic       rise_r;
  logic       fall_r;

  // Synchronize the pin and accept a new level only after it has held FILT_LEN cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
      filt_r <= 1'b1;
      cnt_r  <= 3'd0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], pin};
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      if (sync_r[1] == filt_r) begin
        cnt_r <= 3'd0;
      end else if (cnt_r == LAST_CNT) begin
        filt_r <= sync_r[1];
        cnt_r  <= 3'd0;
        rise_r <= sync_r[1];
        fall_r <= ~sync_r[1];
      end else begin
        cnt_r <= cnt_r + 3'd1;
      end
    end
  end

  assign level = filt_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/i2c_adc_responder.sv
// I2C target emulating the PCF8591 ADC/DAC. Decodes START/STOP on the
// filtered lines, ACKs its address, stores control/DAC bytes and shifts
// out fabric-supplied ADC samples on reads.
// Optional feature macro: I2C_RESP_AUTOINC_EN (channel auto-increment
// after each transmitted read byte when ctrl_byte[2] is set).
module i2c_adc_responder
  import i2c_resp_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEFAULT_ADDR,
  parameter int         FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [7:0] adc_data,
  output logic [1:0] adc_ch,
  output logic       rd_strobe,
  output logic [7:0] ctrl_byte,
  output logic [7:0] dac_data,
  output logic       wr_valid,
  output logic       busy
);

  logic scl_lvl_s, scl_rise_s, scl_fall_s;
  logic sda_lvl_s, sda_rise_s, sda_fall_s;
  logic start_s, stop_s;
  logic [7:0] rx_byte_s;

  state_t     state_r;
  logic [2:0] bit_cnt_r;
  logic [6:0] shift_r;
  logic       ack_phase_r;
  logic       rw_r;
  logic       first_wr_r;
  logic       sda_oe_r;
  logic       busy_r;
  logic [7:0] ctrl_r;
  logic [7:0] dac_r;
  logic [1:0] adc_ch_r;
  logic       rd_strobe_r;
  logic       wr_valid_r;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (scl_i),
    .level (scl_lvl_s),
    .rise  (scl_rise_s),
    .fall  (scl_fall_s)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (sda_i),
    .level (sda_lvl_s),
    .rise  (sda_rise_s),
    .fall  (sda_fall_s)
  );

  // Byte as it would look once the current SDA level is shifted in
  assign rx_byte_s = {shift_r, sda_lvl_s};

  // Bus conditions: SDA edges while filtered SCL is high
  always_comb begin
    start_s = 1'b0;
    stop_s  = 1'b0;
    if (scl_lvl_s) begin
      start_s = sda_fall_s;
      stop_s  = sda_rise_s;
    end else begin
      start_s = 1'b0;
      stop_s  = 1'b0;
    end
  end

  // Protocol engine; START/STOP take priority over any data edge in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 7'h00;
      ack_phase_r <= 1'b0;
      rw_r        <= 1'b0;
      first_wr_r  <= 1'b0;
      sda_oe_r    <= 1'b0;
      busy_r      <= 1'b0;
      ctrl_r      <= 8'h00;
      dac_r       <= 8'h00;
      adc_ch_r    <= 2'd0;
      rd_strobe_r <= 1'b0;
      wr_valid_r  <= 1'b0;
    end else begin
      rd_strobe_r <= 1'b0;
      wr_valid_r  <= 1'b0;
      if (start_s) begin
        state_r     <= ST_ADDR;
        bit_cnt_r   <= 3'd0;
        ack_phase_r <= 1'b0;
        sda_oe_r    <= 1'b0;
        busy_r      <= 1'b1;
      end else if (stop_s) begin
        state_r     <= ST_IDLE;
        bit_cnt_r   <= 3'd0;
        ack_phase_r <= 1'b0;
        sda_oe_r    <= 1'b0;
        busy_r      <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            sda_oe_r <= 1'b0;
          end

          ST_ADDR: begin
            if (scl_rise_s) begin
              shift_r   <= rx_byte_s[6:0];
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                rw_r        <= sda_lvl_s;
                ack_phase_r <= 1'b0;
                state_r     <= (rx_byte_s[7:1] == DEV_ADDR) ? ST_A_ACK : ST_IGNORE;
              end
            end
          end

          // ack_phase_r=0: waiting for the fall after bit 8; 1: ACK is on the bus
          ST_A_ACK: begin
            if (scl_fall_s) begin
              if (!ack_phase_r) begin
                sda_oe_r    <= 1'b1;
                ack_phase_r <= 1'b1;
              end else begin
                ack_phase_r <= 1'b0;
                bit_cnt_r   <= 3'd0;
                if (rw_r) begin
                  shift_r     <= adc_data[6:0];
                  sda_oe_r    <= ~adc_data[7];
                  rd_strobe_r <= 1'b1;
                  state_r     <= ST_RD;
                end else begin
                  sda_oe_r   <= 1'b0;
                  first_wr_r <= 1'b1;
                  state_r    <= ST_WR;
                end
              end
            end
          end

          ST_WR: begin
            if (scl_rise_s) begin
              shift_r   <= rx_byte_s[6:0];
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                wr_valid_r  <= 1'b1;
                ack_phase_r <= 1'b0;
                state_r     <= ST_W_ACK;
                if (first_wr_r) begin
                  ctrl_r     <= rx_byte_s;
                  adc_ch_r   <= rx_byte_s[CH_LSB +: 2];
                  first_wr_r <= 1'b0;
                end else begin
                  dac_r <= rx_byte_s;
                end
              end
            end
          end

          ST_W_ACK: begin
            if (scl_fall_s) begin
              if (!ack_phase_r) begin
                sda_oe_r    <= 1'b1;
                ack_phase_r <= 1'b1;
              end else begin
                sda_oe_r    <= 1'b0;
                ack_phase_r <= 1'b0;
                bit_cnt_r   <= 3'd0;
                state_r     <= ST_WR;
              end
            end
          end

          // Bit 7 is already on the bus when RD is entered; each fall presents the next
          ST_RD: begin
            if (scl_fall_s) begin
              if (bit_cnt_r == 3'd7) begin
                sda_oe_r    <= 1'b0;
                bit_cnt_r   <= 3'd0;
                ack_phase_r <= 1'b0;
                state_r     <= ST_R_ACK;
`ifdef I2C_RESP_AUTOINC_EN
                if (ctrl_r[AUTOINC_BIT]) begin
                  adc_ch_r <= adc_ch_r + 2'd1;
                end
`endif
              end else begin
                sda_oe_r  <= ~shift_r[6];
                shift_r   <= {shift_r[5:0], 1'b0};
                bit_cnt_r <= bit_cnt_r + 3'd1;
              end
            end
          end

          // ack_phase_r=0: sample master ACK/NACK; 1: ACK seen, reload on next fall
          ST_R_ACK: begin
            if (!ack_phase_r) begin
              if (scl_rise_s) begin
                if (sda_lvl_s) begin
                  state_r <= ST_IGNORE;
                end else begin
                  ack_phase_r <= 1'b1;
                end
              end
            end else if (scl_fall_s) begin
              shift_r     <= adc_data[6:0];
              sda_oe_r    <= ~adc_data[7];
              rd_strobe_r <= 1'b1;
              bit_cnt_r   <= 3'd0;
              ack_phase_r <= 1'b0;
              state_r     <= ST_RD;
            end
          end

          ST_IGNORE: begin
            sda_oe_r <= 1'b0;
          end

          default: begin
            state_r  <= ST_IDLE;
            sda_oe_r <= 1'b0;
            busy_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_r;
  assign busy      = busy_r;
  assign ctrl_byte = ctrl_r;
  assign dac_data  = dac_r;
  assign adc_ch    = adc_ch_r;
  assign rd_strobe = rd_strobe_r;
  assign wr_valid  = wr_valid_r;

endmodule
